seq_frame_tx: RTL and testbench
===============================

SEQ_FRAME_TX -- requirements
Module: seq_frame_tx

Interface
REQ-001 Parameter PARITY_EN, default 1: when set to 1, the block SHALL emit a parity bit after the data bits.
REQ-002 Parameter GUARD_CYCLES, default 1, legal range 1..15: this SHALL set the number of low guard cycles after each frame.
REQ-003 Port clk  input  1  SHALL be the clock; all state changes occur on its rising edge.
REQ-004 Port areset  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 Port in_data  input  8  SHALL carry the byte to transmit; it is sampled on acceptance.
REQ-006 Port in_valid  input  1  SHALL indicate that in_data holds a valid byte.
REQ-007 Port in_ready  output  1  SHALL be high when the one-entry holding buffer is empty.
REQ-008 Port tx_out  output  1  SHALL carry the serial bit stream, one bit per clk cycle.
REQ-009 Port tx_active  output  1  SHALL be high during the sync, data and parity bits of a frame.
REQ-010 Port frame_done  output  1  SHALL pulse for one cycle at the end of each frame.

Function
REQ-011 A byte SHALL be accepted on a rising clk edge where in_valid=1 and in_ready=1; it is then written into the holding buffer.
REQ-012 in_ready SHALL be a registered signal equal to NOT(buffer full); it SHALL NOT depend combinationally on in_valid.
REQ-013 The block SHALL be a Moore FSM with these states: IDLE, SYNC0, SYNC1, SYNC2, DATA (8 cycles, bit index 7..0), PAR, GUARD (GUARD_CYCLES cycles).
REQ-014 tx_out, tx_active and frame_done SHALL be decoded from registered state only, with no input-to-output combinational path.
REQ-015 tx_out values by state:
- IDLE = 0
- SYNC0 = 1, SYNC1 = 0, SYNC2 = 1 (the "101" preamble)
- DATA = shift-register MSB, sent MSB-first
- PAR = even-parity bit, i.e. the XOR of the 8 data bits
- GUARD = 0
REQ-016 IDLE -> SYNC0 SHALL occur on the first edge where the buffer is full. On that same edge the buffer SHALL be moved into the shift register and marked empty, so in_ready=1 while the FSM is in SYNC0.
REQ-017 Transition order: SYNC0 -> SYNC1 -> SYNC2 -> DATA (8 cycles) -> PAR, or -> GUARD directly when PARITY_EN=0 -> GUARD (GUARD_CYCLES cycles).
REQ-018 On the last GUARD cycle the FSM SHALL go to SYNC0 if the buffer is full (back-to-back frames, no IDLE cycle), otherwise to IDLE.
REQ-019 Frame length SHALL be exactly 11 + PARITY_EN + GUARD_CYCLES cycles; with default parameters this is 13.
REQ-020 tx_active SHALL be 1 in SYNC0..PAR and 0 in IDLE and GUARD.
REQ-021 frame_done SHALL be 1 only in the first GUARD cycle.
REQ-022 During a frame, a new byte SHALL be accepted into the buffer whenever it is empty; the byte being shifted out SHALL NOT be affected.
REQ-023 While the buffer is full, in_ready=0, and the block SHALL ignore in_data and in_valid.
REQ-024 The guard counter and bit counter SHALL be sized to cover their maximum counts, and SHALL NOT wrap inside a frame.

Reset
REQ-025 When areset=1, the block SHALL immediately force: state=IDLE, tx_out=0, tx_active=0, frame_done=0, buffer empty, in_ready=1, and clear all counters and the shift register.
REQ-026 Reset mid-frame SHALL abort the frame and discard any buffered byte; no partial frame SHALL resume after reset.
REQ-027 The first acceptance SHALL be possible on the first rising edge after areset deasserts.

Verification
REQ-028 Default parameters, send 0xA5 once -> tx_out = 1,0,1, 1,0,1,0,0,1,0,1, 0 (parity), 0 (guard), then IDLE. tx_active is high for 12 cycles; frame_done pulses in cycle 13.
REQ-029 Send 0x01 -> parity bit = 1. Send 0xFF -> parity bit = 0.
REQ-030 Present 0xFF and then 0x00 with in_valid held high -> the second byte is accepted while the FSM is in SYNC0 of frame 1. Frame 2's SYNC0 directly follows frame 1's guard cycle, giving 26 contiguous cycles with no IDLE.
REQ-031 Hold in_valid=1 with three bytes queued -> in_ready=0 while the buffer is full. The third byte is held until the second byte moves into the shift register, and no byte is lost or duplicated.
REQ-032 Assert areset during DATA bit 4 of 0xC3 while 0x3C is buffered -> tx_out=0 immediately and in_ready=1. Nothing further is transmitted until a new byte is accepted.
REQ-033 PARITY_EN=0, GUARD_CYCLES=3, send 0x5A -> 14-cycle frame with no parity bit and 3 low guard cycles; frame_done occurs in cycle 12.

Source files
------------

// File: rtl/seq_frame_tx.sv
// Serialises buffered bytes as "101" + 8 data bits MSB-first + optional even parity + low guard cycles.
// Frame starts one cycle after a byte lands in the one-entry buffer; in_ready is low only while that buffer is full.
module seq_frame_tx #(
  parameter int PARITY_EN    = 1,
  parameter int GUARD_CYCLES = 1
) (
  input  logic       clk,
  input  logic       areset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx_out,
  output logic       tx_active,
  output logic       frame_done
);

  typedef enum logic [2:0] {IDLE, SYNC0, SYNC1, SYNC2, DATA, PAR, GUARD} state_t;

  localparam logic [3:0] GUARD_LAST = 4'(GUARD_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] buf_q, buf_d;
  logic       buf_full_q, buf_full_d;
  logic       par_q, par_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] guard_cnt_q, guard_cnt_d;
  logic       load;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      par_q       <= 1'b0;
      bit_cnt_q   <= '0;
      guard_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      par_q       <= par_d;
      bit_cnt_q   <= bit_cnt_d;
      guard_cnt_q <= guard_cnt_d;
    end
  end

  assign in_ready = ~buf_full_q;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    par_d       = par_q;
    bit_cnt_d   = bit_cnt_q;
    guard_cnt_d = guard_cnt_q;
    load        = 1'b0;
    tx_out      = 1'b0;
    tx_active   = 1'b0;
    frame_done  = 1'b0;

    case (state_q)
      IDLE: begin
        load = buf_full_q;
      end
      SYNC0: begin
        tx_out    = 1'b1;
        tx_active = 1'b1;
        state_d   = SYNC1;
      end
      SYNC1: begin
        tx_active = 1'b1;
        state_d   = SYNC2;
      end
      SYNC2: begin
        tx_out    = 1'b1;
        tx_active = 1'b1;
        state_d   = DATA;
        bit_cnt_d = 3'd7;
      end
      DATA: begin
        tx_out    = shift_q[7];
        tx_active = 1'b1;
        shift_d   = {shift_q[6:0], 1'b0};
        if (bit_cnt_q == 3'd0) begin
          state_d     = (PARITY_EN != 0) ? PAR : GUARD;
          guard_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q - 3'd1;
        end
      end
      PAR: begin
        tx_out      = par_q;
        tx_active   = 1'b1;
        state_d     = GUARD;
        guard_cnt_d = '0;
      end
      GUARD: begin
        frame_done = (guard_cnt_q == 4'd0);
        if (guard_cnt_q == GUARD_LAST) begin
          // Chain straight into the next frame when a byte is already waiting.
          load = buf_full_q;
          if (!buf_full_q) state_d = IDLE;
        end else begin
          guard_cnt_d = guard_cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Load and accept are exclusive: one needs a full buffer, the other an empty one.
    if (load) begin
      state_d     = SYNC0;
      shift_d     = buf_q;
      par_d       = ^buf_q;
      buf_full_d  = 1'b0;
      guard_cnt_d = '0;
    end else if (in_valid && !buf_full_q) begin
      buf_d      = in_data;
      buf_full_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Bench for seq_frame_tx: default-parameter instance plus a PARITY_EN=0 / GUARD_CYCLES=3 instance,
// both compared every cycle against a frame-timeline reference model.
module tb_seq_frame_tx;

  logic       clk = 1'b0;
  logic       areset = 1'b1;
  logic       v [2];
  logic [7:0] d [2];
  logic       rdy [2];
  logic       tx [2];
  logic       act [2];
  logic       done [2];

  always #5 clk = ~clk;

  seq_frame_tx dut0 (
    .clk(clk), .areset(areset), .in_data(d[0]), .in_valid(v[0]),
    .in_ready(rdy[0]), .tx_out(tx[0]), .tx_active(act[0]), .frame_done(done[0])
  );

  seq_frame_tx #(.PARITY_EN(0), .GUARD_CYCLES(3)) dut1 (
    .clk(clk), .areset(areset), .in_data(d[1]), .in_valid(v[1]),
    .in_ready(rdy[1]), .tx_out(tx[1]), .tx_active(act[1]), .frame_done(done[1])
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: remaining cycles of the frame on the wire, its byte, and the holding buffer.
  int         pe [2];
  int         gc [2];
  int         rem [2];
  logic [7:0] cur [2];
  logic [7:0] mbuf [2];
  logic       mfull [2];
  logic       macc [2];
  logic [7:0] sent_b [2][512];
  int         sent_n [2];

  logic tx_log [2][4096];
  logic act_log [2][4096];
  logic done_log [2][4096];
  logic rdy_log [2][4096];

  task automatic chk(string tag, logic obs, logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, expv);
    end
  endtask

  task automatic chki(string tag, int obs, int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [2:0] exp_out(int k);
    int len, pos;
    if (rem[k] == 0) return 3'b000;
    len = 11 + pe[k] + gc[k];
    pos = len - rem[k];
    if (pos < 3) return {pos != 1, 2'b10};
    if (pos < 11) return {cur[k][10 - pos], 2'b10};
    if (pe[k] == 1 && pos == 11) return {^cur[k], 2'b10};
    return {2'b00, pos == 11 + pe[k]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      rem[k] = 0;
      mfull[k] = 1'b0;
      macc[k] = 1'b0;
    end
  endtask

  task automatic model_step(int k);
    macc[k] = 1'b0;
    if (rem[k] > 0) rem[k]--;
    if (rem[k] == 0 && mfull[k]) begin
      cur[k] = mbuf[k];
      rem[k] = 11 + pe[k] + gc[k];
      mfull[k] = 1'b0;
    end else if (v[k] && !mfull[k]) begin
      mbuf[k] = d[k];
      mfull[k] = 1'b1;
      macc[k] = 1'b1;
      if (sent_n[k] < 512) sent_b[k][sent_n[k]] = d[k];
      sent_n[k]++;
    end
  endtask

  task automatic check_now(string tag);
    logic [2:0] e;
    for (int k = 0; k < 2; k++) begin
      e = exp_out(k);
      chk($sformatf("%s_tx%0d", tag, k), tx[k], e[2]);
      chk($sformatf("%s_active%0d", tag, k), act[k], e[1]);
      chk($sformatf("%s_done%0d", tag, k), done[k], e[0]);
      chk($sformatf("%s_ready%0d", tag, k), rdy[k], !mfull[k]);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      tx_log[k][cyc] = tx[k];
      act_log[k][cyc] = act[k];
      done_log[k][cyc] = done[k];
      rdy_log[k][cyc] = rdy[k];
    end
    check_now($sformatf("cyc%0d", cyc));
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k);
    cyc++;
    #1;
  endtask

  task automatic apply_reset(string tag);
    areset = 1'b1;
    #1;
    model_reset();
    check_now(tag);
    @(posedge clk);
    #1;
    areset = 1'b0;
  endtask

  task automatic idle(int n);
    v[0] = 1'b0;
    v[1] = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Rebuild bytes from the DUT's serial log and match them against accepted bytes.
  task automatic check_frames(int k, int from, int to, string tag);
    int m;
    logic [7:0] b;
    m = 0;
    for (int i = from; i < to; i++) begin
      if (act_log[k][i] && !act_log[k][i-1]) begin
        for (int j = 0; j < 8; j++) b[7-j] = tx_log[k][i+3+j];
        if (m < sent_n[k]) chki($sformatf("%s_byte%0d", tag, m), b, sent_b[k][m]);
        m++;
      end
    end
    chki({tag, "_count"}, m, sent_n[k]);
  endtask

  task automatic send_one(int k, logic [7:0] b, output int s);
    s = cyc + 2;
    v[k] = 1'b1;
    d[k] = b;
    tick();
    v[k] = 1'b0;
  endtask

  initial begin
    int s, t0, n, idx, rs;
    logic [12:0] seq13;
    logic [13:0] seq14;
    logic [7:0] list [3];
    pe[0] = 1; gc[0] = 1;
    pe[1] = 0; gc[1] = 3;
    sent_n[0] = 0; sent_n[1] = 0;
    for (int k = 0; k < 2; k++) begin v[k] = 1'b0; d[k] = 8'h00; end
    #2;
    apply_reset("reset");
    idle(3);

    // 0xA5 on the default instance
    send_one(0, 8'hA5, s);
    idle(16);
    for (int i = 0; i < 13; i++) seq13[12-i] = tx_log[0][s+i];
    chki("a5_bits", seq13, 13'b1011010010100);
    n = 0;
    for (int i = s - 1; i < s + 14; i++) n += act_log[0][i];
    chki("a5_active_cycles", n, 12);
    chk("a5_done_cycle13", done_log[0][s+12], 1'b1);
    n = 0;
    for (int i = s - 1; i < s + 14; i++) n += done_log[0][i];
    chki("a5_done_pulses", n, 1);

    // Parity extremes
    send_one(0, 8'h01, s);
    idle(16);
    chk("parity_01", tx_log[0][s+11], 1'b1);
    send_one(0, 8'hFF, s);
    idle(16);
    chk("parity_ff", tx_log[0][s+11], 1'b0);

    // Back-to-back: 0xFF then 0x00 with in_valid held
    t0 = cyc;
    v[0] = 1'b1; d[0] = 8'hFF;
    tick();
    d[0] = 8'h00;
    tick();
    tick();
    v[0] = 1'b0;
    chk("b2b_ready_in_sync0", rdy_log[0][t0+2], 1'b1);
    chk("b2b_accept_in_sync0", macc[0], 1'b1);
    idle(32);
    n = 0;
    for (int i = t0 + 2; i < t0 + 28; i++) n += (act_log[0][i] | done_log[0][i]);
    chki("b2b_contiguous", n, 26);
    chk("b2b_frame2_sync0", tx_log[0][t0+15], 1'b1);
    chk("b2b_after_idle", act_log[0][t0+28], 1'b0);

    // Three bytes queued with in_valid held high
    sent_n[0] = 0;
    rs = cyc;
    list[0] = 8'h12; list[1] = 8'h34; list[2] = 8'h56;
    idx = 0;
    v[0] = 1'b1; d[0] = list[0];
    for (int i = 0; i < 100 && idx < 3; i++) begin
      tick();
      if (macc[0]) begin
        idx++;
        if (idx < 3) d[0] = list[idx];
      end
    end
    v[0] = 1'b0;
    chki("queue3_accepted", idx, 3);
    idle(40);
    n = 0;
    for (int i = rs; i < cyc; i++) n += !rdy_log[0][i];
    chk("queue3_ready_low_seen", n > 2, 1'b1);
    check_frames(0, rs, cyc - 15, "queue3");

    // Reset during DATA bit 4 of 0xC3 with 0x3C buffered
    v[0] = 1'b1; d[0] = 8'hC3;
    tick();
    d[0] = 8'h3C;
    for (int i = 0; i < 10 && !macc[0]; i++) tick();
    v[0] = 1'b0;
    chk("mid_3c_buffered", mfull[0], 1'b1);
    n = 0;
    for (int i = 0; i < 50 && rem[0] != 7; i++) begin tick(); n++; end
    chki("mid_reached_bit4", rem[0], 7);
    #3;
    chk("mid_active_before", act[0], 1'b1);
    apply_reset("mid_reset");
    chk("mid_tx_low", tx[0], 1'b0);
    chk("mid_ready_high", rdy[0], 1'b1);
    t0 = cyc;
    idle(20);
    n = 0;
    for (int i = t0; i < cyc; i++) n += act_log[0][i];
    chki("mid_nothing_after", n, 0);

    // PARITY_EN=0, GUARD_CYCLES=3 instance
    send_one(1, 8'h5A, s);
    idle(18);
    for (int i = 0; i < 14; i++) seq14[13-i] = tx_log[1][s+i];
    chki("np_bits", seq14, 14'b10101011010000);
    chk("np_done_cycle12", done_log[1][s+11], 1'b1);
    n = 0;
    for (int i = s; i < s + 15; i++) n += act_log[1][i];
    chki("np_active_cycles", n, 11);
    chk("np_sync_next_idle", act_log[1][s+14], 1'b0);

    // Random traffic on both instances
    sent_n[0] = 0; sent_n[1] = 0;
    rs = cyc;
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 2; k++) begin
        v[k] = ($urandom_range(0, 99) < 40);
        d[k] = 8'($urandom);
      end
      tick();
    end
    idle(40);
    check_frames(0, rs, cyc - 15, "rnd0");
    check_frames(1, rs, cyc - 15, "rnd1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
